// File: rtl/exc_irq_ctrl.sv
// Registered exception/interrupt controller: edge-latched masked IRQs with fixed priority,
// invalid-opcode trap and ERET return. Define IRQ_SYNC_EN to add 2-flop irq synchronisers.
module exc_irq_ctrl #(
   parameter  int NUM_IRQ = 4,
   localparam int IDW     = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               instr_valid,
   input  logic               invalid_op,
   input  logic               eret,
   input  logic [NUM_IRQ-1:0] irq,
   input  logic [NUM_IRQ-1:0] irq_mask,
   input  logic [NUM_IRQ-1:0] irq_clr,
   output logic               exc_take,
   output logic               eret_ack,
   output logic [3:0]         estatus,
   output logic [IDW-1:0]     irq_id,
   output logic [NUM_IRQ-1:0] pending,
   output logic               busy,
   output logic               nested_err
);

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_TAKE    = 2'd1,
      ST_HANDLER = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [NUM_IRQ-1:0] w_irq_s;
   logic [NUM_IRQ-1:0] r_irq_prev;
   logic [NUM_IRQ-1:0] w_rise;
   logic [NUM_IRQ-1:0] r_pending;
   logic [NUM_IRQ-1:0] w_cand;
   logic [NUM_IRQ-1:0] w_winner_oh;
   logic [NUM_IRQ-1:0] w_take_clr;
   logic [IDW-1:0]     w_winner;
   logic [IDW-1:0]     r_irq_id;
   logic [3:0]         r_estatus;
   logic               r_eret_ack;
   logic               r_nested_err;
   logic               w_trap;
   logic               w_do_trap;
   logic               w_do_irq;
   logic               w_do_eret;
   logic               w_exc_take;
   logic               w_busy;

`ifdef IRQ_SYNC_EN
   logic [NUM_IRQ-1:0] r_sync1;
   logic [NUM_IRQ-1:0] r_sync2;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= irq;
         r_sync2 <= r_sync1;
      end
   end

   assign w_irq_s = r_sync2;
`else
   assign w_irq_s = irq;
`endif

   assign w_rise = w_irq_s & ~r_irq_prev;
   assign w_cand = r_pending & irq_mask;

   // Descending scan so the lowest set index is the final assignment.
   always_comb begin
      w_winner    = '0;
      w_winner_oh = '0;
      for (int unsigned i = NUM_IRQ; i > 0; i--) begin
         if (w_cand[i-1]) begin
            w_winner         = IDW'(i - 1);
            w_winner_oh      = '0;
            w_winner_oh[i-1] = 1'b1;
         end
      end
   end

   assign w_trap     = instr_valid & invalid_op;
   assign w_do_trap  = (r_state == ST_RUN) & w_trap;
   assign w_do_irq   = (r_state == ST_RUN) & ~w_trap & (|w_cand);
   assign w_do_eret  = (r_state == ST_HANDLER) & instr_valid & eret;
   assign w_take_clr = {NUM_IRQ{w_do_irq}} & w_winner_oh;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= ST_RUN;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_RUN:     if (w_do_trap || w_do_irq) w_state_nxt = ST_TAKE;
         ST_TAKE:    w_state_nxt = ST_HANDLER;
         ST_HANDLER: if (w_do_eret) w_state_nxt = ST_RUN;
         default:    w_state_nxt = ST_RUN;
      endcase
   end

   always_comb begin
      w_exc_take = 1'b0;
      w_busy     = 1'b1;
      case (r_state)
         ST_RUN:  w_busy     = 1'b0;
         ST_TAKE: w_exc_take = 1'b1;
         default: w_busy     = 1'b1;
      endcase
   end

   // New edges are OR-ed in last so a same-cycle set beats both ack and take clears.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_irq_prev   <= '0;
         r_pending    <= '0;
         r_estatus    <= '0;
         r_irq_id     <= '0;
         r_eret_ack   <= 1'b0;
         r_nested_err <= 1'b0;
      end else begin
         r_irq_prev <= w_irq_s;
         r_pending  <= (r_pending & ~irq_clr & ~w_take_clr) | w_rise;
         r_eret_ack <= w_do_eret;
         if (w_do_trap) begin
            r_estatus <= 4'b0010;
         end else if (w_do_irq) begin
            r_estatus <= 4'b0001;
            r_irq_id  <= w_winner;
         end else if (w_do_eret) begin
            r_estatus <= 4'b0000;
         end
         if ((r_state == ST_HANDLER) && w_trap && !eret)
            r_nested_err <= 1'b1;
      end
   end

   assign exc_take   = w_exc_take;
   assign busy       = w_busy;
   assign eret_ack   = r_eret_ack;
   assign estatus    = r_estatus;
   assign irq_id     = r_irq_id;
   assign pending    = r_pending;
   assign nested_err = r_nested_err;

endmodule

// File: tb/tb_exc_irq_ctrl.sv
// Directed bench for exc_irq_ctrl (NUM_IRQ=4): take/priority, trap, ERET, masking, latency, reset.
module tb_exc_irq_ctrl;

`ifdef IRQ_SYNC_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 1;
`endif

   logic       clk = 1'b0;
   logic       reset_n;
   logic       instr_valid;
   logic       invalid_op;
   logic       eret;
   logic [3:0] irq;
   logic [3:0] irq_mask;
   logic [3:0] irq_clr;
   logic       exc_take;
   logic       eret_ack;
   logic [3:0] estatus;
   logic [1:0] irq_id;
   logic [3:0] pending;
   logic       busy;
   logic       nested_err;

   int total = 0;
   int bad   = 0;

   exc_irq_ctrl #(.NUM_IRQ(4)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .instr_valid(instr_valid),
      .invalid_op (invalid_op),
      .eret       (eret),
      .irq        (irq),
      .irq_mask   (irq_mask),
      .irq_clr    (irq_clr),
      .exc_take   (exc_take),
      .eret_ack   (eret_ack),
      .estatus    (estatus),
      .irq_id     (irq_id),
      .pending    (pending),
      .busy       (busy),
      .nested_err (nested_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_eret();
      instr_valid = 1'b1; eret = 1'b1;
      tick();
      instr_valid = 1'b0; eret = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; instr_valid = 1'b0; invalid_op = 1'b0; eret = 1'b0;
      irq = 4'b0000; irq_mask = 4'b0000; irq_clr = 4'b0000;
      tick(); tick();
      total++; if (estatus !== 4'b0000) begin bad++; $display("FAIL reset_estatus got=%b exp=0000", estatus); end
      total++; if ({exc_take, eret_ack, busy, nested_err} !== 4'b0000) begin bad++; $display("FAIL reset_flags got=%b exp=0000", {exc_take, eret_ack, busy, nested_err}); end
      total++; if ({pending, irq_id} !== 6'd0) begin bad++; $display("FAIL reset_pend_id got=%b exp=000000", {pending, irq_id}); end
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_irq_take();
      irq_mask = 4'b1111; irq = 4'b0110;
      repeat (LAT) tick();
      total++; if (pending !== 4'b0110) begin bad++; $display("FAIL t2_pending got=%b exp=0110", pending); end
      total++; if (exc_take !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL t2_pre got=%b%b exp=00", exc_take, busy); end
      tick();
      total++; if (exc_take !== 1'b1) begin bad++; $display("FAIL t2_take got=%b exp=1", exc_take); end
      total++; if (estatus !== 4'b0001) begin bad++; $display("FAIL t2_estatus got=%b exp=0001", estatus); end
      total++; if (irq_id !== 2'd1) begin bad++; $display("FAIL t2_irq_id got=%0d exp=1", irq_id); end
      total++; if (pending !== 4'b0100) begin bad++; $display("FAIL t2_pending_after got=%b exp=0100", pending); end
      tick();
      total++; if ({exc_take, busy} !== 2'b01) begin bad++; $display("FAIL t2_handler got=%b exp=01", {exc_take, busy}); end
      total++; if (pending !== 4'b0100) begin bad++; $display("FAIL t2_no_nest got=%b exp=0100", pending); end
   endtask

   task automatic test_nested_and_eret();
      instr_valid = 1'b1; invalid_op = 1'b1;
      tick();
      instr_valid = 1'b0; invalid_op = 1'b0;
      total++; if (nested_err !== 1'b1) begin bad++; $display("FAIL nested_set got=%b exp=1", nested_err); end
      total++; if (estatus !== 4'b0001 || busy !== 1'b1) begin bad++; $display("FAIL nested_hold got=%b/%b exp=0001/1", estatus, busy); end
      instr_valid = 1'b1; invalid_op = 1'b1; eret = 1'b1;
      tick();
      instr_valid = 1'b0; invalid_op = 1'b0; eret = 1'b0;
      total++; if (eret_ack !== 1'b1) begin bad++; $display("FAIL t4_eret_ack got=%b exp=1", eret_ack); end
      total++; if (estatus !== 4'b0000 || busy !== 1'b0) begin bad++; $display("FAIL t4_return got=%b/%b exp=0000/0", estatus, busy); end
      total++; if (irq_id !== 2'd1) begin bad++; $display("FAIL t4_id_held got=%0d exp=1", irq_id); end
      tick();
      total++; if (eret_ack !== 1'b0) begin bad++; $display("FAIL t4_ack_pulse got=%b exp=0", eret_ack); end
      total++; if (exc_take !== 1'b1 || estatus !== 4'b0001 || irq_id !== 2'd2) begin bad++; $display("FAIL t4_retake got=%b/%b/%0d exp=1/0001/2", exc_take, estatus, irq_id); end
      total++; if (pending !== 4'b0000) begin bad++; $display("FAIL t4_pending got=%b exp=0000", pending); end
      tick();
      do_eret();
      tick();
      total++; if ({exc_take, busy, eret_ack} !== 3'b000) begin bad++; $display("FAIL t4_idle got=%b exp=000", {exc_take, busy, eret_ack}); end
      total++; if (nested_err !== 1'b1) begin bad++; $display("FAIL nested_sticky got=%b exp=1", nested_err); end
      instr_valid = 1'b1; eret = 1'b1;
      tick();
      instr_valid = 1'b0; eret = 1'b0;
      total++; if ({eret_ack, busy} !== 2'b00) begin bad++; $display("FAIL eret_in_run got=%b exp=00", {eret_ack, busy}); end
   endtask

   task automatic test_trap_priority();
      irq = 4'b0000; irq_mask = 4'b0000;
      repeat (LAT + 1) tick();
      irq = 4'b0001;
      repeat (LAT) tick();
      total++; if (pending !== 4'b0001) begin bad++; $display("FAIL t3_pending got=%b exp=0001", pending); end
      irq_mask = 4'b1111; instr_valid = 1'b1; invalid_op = 1'b1;
      tick();
      instr_valid = 1'b0; invalid_op = 1'b0;
      total++; if (exc_take !== 1'b1 || estatus !== 4'b0010) begin bad++; $display("FAIL t3_trap got=%b/%b exp=1/0010", exc_take, estatus); end
      total++; if (pending !== 4'b0001) begin bad++; $display("FAIL t3_irq_kept got=%b exp=0001", pending); end
      tick();
      do_eret();
      total++; if (estatus !== 4'b0000) begin bad++; $display("FAIL t3_eret got=%b exp=0000", estatus); end
      tick();
      total++; if (exc_take !== 1'b1 || estatus !== 4'b0001 || irq_id !== 2'd0) begin bad++; $display("FAIL t3_irq_after got=%b/%b/%0d exp=1/0001/0", exc_take, estatus, irq_id); end
      tick();
      do_eret();
      tick();
   endtask

   task automatic test_mask_clr();
      irq = 4'b0000; irq_mask = 4'b0111;
      repeat (LAT + 1) tick();
      irq = 4'b1000;
      repeat (LAT) tick();
      total++; if (pending !== 4'b1000) begin bad++; $display("FAIL t5_pending got=%b exp=1000", pending); end
      tick();
      total++; if ({exc_take, busy} !== 2'b00) begin bad++; $display("FAIL t5_masked got=%b exp=00", {exc_take, busy}); end
      irq_clr = 4'b1000;
      tick();
      irq_clr = 4'b0000;
      total++; if (pending !== 4'b0000) begin bad++; $display("FAIL t5_clr got=%b exp=0000", pending); end
      irq = 4'b0000;
      repeat (LAT + 1) tick();
      irq = 4'b1000;
      repeat (LAT - 1) tick();
      irq_clr = 4'b1000;
      tick();
      irq_clr = 4'b0000;
      total++; if (pending !== 4'b1000) begin bad++; $display("FAIL t5_set_wins got=%b exp=1000", pending); end
   endtask

   task automatic test_latency();
      irq_clr = 4'b1000; irq_mask = 4'b0001; irq = 4'b0000;
      tick();
      irq_clr = 4'b0000;
      repeat (LAT + 1) tick();
      irq = 4'b0001;
      for (int c = 1; c < LAT; c++) begin
         tick();
         total++; if (pending[0] !== 1'b0) begin bad++; $display("FAIL t6_early c=%0d got=%b exp=0", c, pending[0]); end
      end
      tick();
      total++; if (pending[0] !== 1'b1 || exc_take !== 1'b0) begin bad++; $display("FAIL t6_pending got=%b/%b exp=1/0", pending[0], exc_take); end
      tick();
      total++; if (exc_take !== 1'b1 || irq_id !== 2'd0) begin bad++; $display("FAIL t6_take got=%b/%0d exp=1/0", exc_take, irq_id); end
      tick();
   endtask

   task automatic test_reset_mid();
      irq = 4'b0010;
      total++; if (busy !== 1'b1 || estatus !== 4'b0001) begin bad++; $display("FAIL t1_pre got=%b/%b exp=1/0001", busy, estatus); end
      reset_n = 1'b0;
      #1;
      total++; if ({exc_take, eret_ack, busy, nested_err} !== 4'b0000) begin bad++; $display("FAIL t1_flags got=%b exp=0000", {exc_take, eret_ack, busy, nested_err}); end
      total++; if ({estatus, irq_id, pending} !== 10'd0) begin bad++; $display("FAIL t1_data got=%b exp=0", {estatus, irq_id, pending}); end
      tick();
      reset_n = 1'b1;
      repeat (LAT) tick();
      total++; if (busy !== 1'b0 || pending !== 4'b0010) begin bad++; $display("FAIL t1_release got=%b/%b exp=0/0010", busy, pending); end
   endtask

   initial begin
      test_reset();
      test_irq_take();
      test_nested_and_eret();
      test_trap_priority();
      test_mask_clr();
      test_latency();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
